// File: rtl/sonar_scheduler.sv
// sonar_scheduler: alternates trigger pings between two ultrasonic sensors,
// measures each echo pulse width, and keeps per-sensor "near object" flags
// that assert after a run of consecutive short echoes.
module sonar_scheduler #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GAP_CYCLES     = 500000,
  parameter int THRESH_CYCLES  = 87000,
  parameter int HITS           = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        echo0,
  input  logic        echo1,
  output logic        trig0,
  output logic        trig1,
  output logic [21:0] width,
  output logic        width_valid,
  output logic        width_id,
  output logic        tmo,
  output logic        det0,
  output logic        det1
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam logic [21:0] TRIG_LAST = 22'(TRIG_CYCLES - 1);
  localparam logic [21:0] TMO_LAST  = 22'(TIMEOUT_CYCLES - 1);
  localparam logic [21:0] TMO_FULL  = 22'(TIMEOUT_CYCLES);
  localparam logic [21:0] GAP_LAST  = 22'(GAP_CYCLES - 1);
  localparam logic [21:0] THRESH    = 22'(THRESH_CYCLES);
  localparam logic [3:0]  HITS_SAT  = 4'(HITS);

  state_t      state_r, state_s;
  logic        sel_r, sel_s;
  logic [21:0] cnt_r, cnt_s;
  logic [1:0]  echo_meta_r, echo_sync_r, echo_prev_r;
  logic        echo_sel_s, rise_s;
  logic        done_s, tmo_s, hit_s;
  logic [21:0] width_s;
  logic [3:0]  hcnt0_r, hcnt1_r, hnext0_s, hnext1_s;
  logic        trig0_r, trig1_r, width_valid_r, width_id_r, tmo_r, det0_r, det1_r;
  logic [21:0] width_r;

  assign trig0       = trig0_r;
  assign trig1       = trig1_r;
  assign width       = width_r;
  assign width_valid = width_valid_r;
  assign width_id    = width_id_r;
  assign tmo         = tmo_r;
  assign det0        = det0_r;
  assign det1        = det1_r;

  // Two-flop synchronizers plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_meta_r <= 2'b00;
      echo_sync_r <= 2'b00;
      echo_prev_r <= 2'b00;
    end else begin
      echo_meta_r <= {echo1, echo0};
      echo_sync_r <= echo_meta_r;
      echo_prev_r <= echo_sync_r;
    end
  end

  // Selected echo level and its 0->1 edge.
  always_comb begin
    echo_sel_s = echo_sync_r[sel_r];
    rise_s     = echo_sync_r[sel_r] & ~echo_prev_r[sel_r];
  end

  // Next-state logic: phase sequencing, cycle counter and measurement exits.
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    cnt_s   = cnt_r + 22'd1;
    done_s  = 1'b0;
    tmo_s   = 1'b0;
    width_s = cnt_r;
    if (!enable) begin
      state_s = IDLE;
      sel_s   = 1'b0;
      cnt_s   = 22'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = TRIG;
          cnt_s   = 22'd0;
        end
        TRIG: begin
          if (cnt_r == TRIG_LAST) begin
            state_s = WAIT_RISE;
            cnt_s   = 22'd0;
          end else begin
            state_s = TRIG;
          end
        end
        WAIT_RISE: begin
          if (rise_s) begin
            // The rise cycle is already the first high cycle of the echo.
            state_s = MEASURE;
            cnt_s   = 22'd1;
          end else if (cnt_r == TMO_LAST) begin
            state_s = GAP;
            cnt_s   = 22'd0;
            done_s  = 1'b1;
            tmo_s   = 1'b1;
            width_s = 22'd0;
          end else begin
            state_s = WAIT_RISE;
          end
        end
        MEASURE: begin
          if (!echo_sel_s) begin
            state_s = GAP;
            cnt_s   = 22'd0;
            done_s  = 1'b1;
            width_s = cnt_r;
          end else if (cnt_r == TMO_LAST) begin
            state_s = GAP;
            cnt_s   = 22'd0;
            done_s  = 1'b1;
            tmo_s   = 1'b1;
            width_s = TMO_FULL;
          end else begin
            state_s = MEASURE;
          end
        end
        GAP: begin
          if (cnt_r == GAP_LAST) begin
            state_s = TRIG;
            sel_s   = ~sel_r;
            cnt_s   = 22'd0;
          end else begin
            state_s = GAP;
          end
        end
        default: begin
          state_s = IDLE;
          sel_s   = 1'b0;
          cnt_s   = 22'd0;
        end
      endcase
    end
  end

  // Hit classification and saturating increments of the per-sensor counters.
  always_comb begin
    hit_s = done_s & ~tmo_s & (width_s < THRESH);
    if (hcnt0_r >= HITS_SAT) begin
      hnext0_s = HITS_SAT;
    end else begin
      hnext0_s = hcnt0_r + 4'd1;
    end
    if (hcnt1_r >= HITS_SAT) begin
      hnext1_s = HITS_SAT;
    end else begin
      hnext1_s = hcnt1_r + 4'd1;
    end
  end

  // FSM state, sensor select, counter, triggers and measurement outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      sel_r         <= 1'b0;
      cnt_r         <= 22'd0;
      trig0_r       <= 1'b0;
      trig1_r       <= 1'b0;
      width_valid_r <= 1'b0;
      width_r       <= 22'd0;
      width_id_r    <= 1'b0;
      tmo_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      sel_r         <= sel_s;
      cnt_r         <= cnt_s;
      trig0_r       <= (state_s == TRIG) & ~sel_s;
      trig1_r       <= (state_s == TRIG) & sel_s;
      width_valid_r <= done_s;
      if (done_s) begin
        width_r    <= width_s;
        width_id_r <= sel_r;
        tmo_r      <= tmo_s;
      end else begin
        width_r    <= width_r;
        width_id_r <= width_id_r;
        tmo_r      <= tmo_r;
      end
    end
  end

  // Per-sensor consecutive-hit counters and detect flags; cleared when disarmed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt0_r <= 4'd0;
      hcnt1_r <= 4'd0;
      det0_r  <= 1'b0;
      det1_r  <= 1'b0;
    end else if (!enable) begin
      hcnt0_r <= 4'd0;
      hcnt1_r <= 4'd0;
      det0_r  <= 1'b0;
      det1_r  <= 1'b0;
    end else if (done_s && sel_r) begin
      hcnt1_r <= hit_s ? hnext1_s : 4'd0;
      det1_r  <= hit_s & (hnext1_s == HITS_SAT);
    end else if (done_s) begin
      hcnt0_r <= hit_s ? hnext0_s : 4'd0;
      det0_r  <= hit_s & (hnext0_s == HITS_SAT);
    end else begin
      hcnt0_r <= hcnt0_r;
      hcnt1_r <= hcnt1_r;
      det0_r  <= det0_r;
      det1_r  <= det1_r;
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed scenarios for the two-sensor ping scheduler.
`timescale 1ns/1ps
module tb_sonar_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable, echo0, echo1;
  logic        trig0, trig1, width_valid, width_id, tmo, det0, det1;
  logic [21:0] width;
  int          errors = 0;
  int          checks = 0;

  sonar_scheduler #(
    .TRIG_CYCLES(4), .TIMEOUT_CYCLES(100), .GAP_CYCLES(10),
    .THRESH_CYCLES(50), .HITS(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo0(echo0), .echo1(echo1),
    .trig0(trig0), .trig1(trig1), .width(width), .width_valid(width_valid),
    .width_id(width_id), .tmo(tmo), .det0(det0), .det1(det1)
  );

  always #5 clk = ~clk;

  // Wait for either trigger to rise; also note any width_valid seen meanwhile.
  task automatic wait_trig(input int max, output bit ok, output bit which,
                           output int waited, output bit wv_seen);
    ok = 1'b0; which = 1'b0; waited = 0; wv_seen = 1'b0;
    while (!ok && waited < max) begin
      @(negedge clk);
      waited++;
      if (trig0 || trig1) begin
        ok = 1'b1;
        which = trig1;
      end else if (width_valid) begin
        wv_seen = 1'b1;
      end
    end
  endtask

  // Count how many cycles the active trigger stays high; returns at its fall.
  task automatic trig_len(input bit which, output int len, output bit other_seen);
    len = 1;
    other_seen = which ? trig0 : trig1;
    while (len < 50) begin
      @(negedge clk);
      if (which ? trig1 : trig0) begin
        len++;
        other_seen |= which ? trig0 : trig1;
      end else begin
        break;
      end
    end
  endtask

  // One ping: wait for trigger, then drive echo high for n_high cycles from
  // WAIT_RISE entry (k=0) and echo on the other sensor for other_n cycles.
  task automatic do_ping(input int n_high, input int other_n,
                         output bit trig_ok, output bit which, output int gap_wait,
                         output bit wv_gap, output int tlen, output bit other_seen,
                         output bit wv_ok, output int wv_k);
    wait_trig(300, trig_ok, which, gap_wait, wv_gap);
    tlen = 0; other_seen = 1'b0; wv_ok = 1'b0; wv_k = 0;
    if (trig_ok) begin
      trig_len(which, tlen, other_seen);
      while (!wv_ok && wv_k < 300) begin
        if (which) begin
          echo1 = (wv_k < n_high);
          echo0 = (wv_k < other_n);
        end else begin
          echo0 = (wv_k < n_high);
          echo1 = (wv_k < other_n);
        end
        @(negedge clk);
        wv_k++;
        if (width_valid) wv_ok = 1'b1;
      end
      echo0 = 1'b0;
      echo1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit act;
    reset = 1'b1; enable = 1'b0; echo0 = 1'b0; echo1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({trig0, trig1, width, width_valid, width_id, tmo, det0, det1} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {trig0, trig1, width, width_valid, width_id, tmo, det0, det1});
    end
    reset = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 8; i++) begin
      echo0 = i[0];
      @(negedge clk);
      act |= trig0 | trig1 | width_valid;
    end
    echo0 = 1'b0;
    checks++;
    if (act !== 1'b0) begin
      errors++;
      $display("FAIL idle_disabled: got activity=%0d expected 0", act);
    end
  endtask

  task automatic test_basic();
    bit trig_ok, which, wv_gap, other_seen, wv_ok;
    int gap_wait, tlen, wv_k;
    enable = 1'b1;
    do_ping(30, 0, trig_ok, which, gap_wait, wv_gap, tlen, other_seen, wv_ok, wv_k);
    checks++;
    if ({trig_ok, which} !== 2'b10) begin
      errors++; $display("FAIL first_ping: got ok,sel=%b%b expected 10", trig_ok, which);
    end
    checks++;
    if (tlen !== 4) begin
      errors++; $display("FAIL trig0_len: got %0d expected 4", tlen);
    end
    checks++;
    if (other_seen !== 1'b0) begin
      errors++; $display("FAIL trig1_quiet: got %0d expected 0", other_seen);
    end
    checks++;
    if (wv_ok !== 1'b1 || wv_k !== 33) begin
      errors++; $display("FAIL basic_latency: got ok=%0d k=%0d expected ok=1 k=33", wv_ok, wv_k);
    end
    checks++;
    if ({width_id, tmo, width} !== {1'b0, 1'b0, 22'd30}) begin
      errors++; $display("FAIL basic_meas: got id=%0d tmo=%0d w=%0d expected 0 0 30", width_id, tmo, width);
    end
    checks++;
    if (det0 !== 1'b0) begin
      errors++; $display("FAIL basic_det0: got %0d expected 0", det0);
    end
  endtask

  task automatic test_timeout_wait();
    bit trig_ok, which, wv_gap, other_seen, wv_ok;
    int gap_wait, tlen, wv_k;
    do_ping(0, 20, trig_ok, which, gap_wait, wv_gap, tlen, other_seen, wv_ok, wv_k);
    checks++;
    if (gap_wait !== 10 || wv_gap !== 1'b0) begin
      errors++; $display("FAIL gap_len: got gap=%0d extra_wv=%0d expected 10 0", gap_wait, wv_gap);
    end
    checks++;
    if ({trig_ok, which, other_seen} !== 3'b110 || tlen !== 4) begin
      errors++; $display("FAIL second_ping: got ok,sel,other=%b%b%b len=%0d expected 110 4",
                         trig_ok, which, other_seen, tlen);
    end
    checks++;
    if (wv_ok !== 1'b1 || wv_k !== 100) begin
      errors++; $display("FAIL wait_timeout_time: got ok=%0d k=%0d expected ok=1 k=100", wv_ok, wv_k);
    end
    checks++;
    if ({width_id, tmo, width, det1} !== {1'b1, 1'b1, 22'd0, 1'b0}) begin
      errors++; $display("FAIL wait_timeout: got id=%0d tmo=%0d w=%0d det1=%0d expected 1 1 0 0",
                         width_id, tmo, width, det1);
    end
  endtask

  task automatic test_long_miss();
    bit trig_ok, which, wv_gap, other_seen, wv_ok;
    int gap_wait, tlen, wv_k;
    do_ping(60, 0, trig_ok, which, gap_wait, wv_gap, tlen, other_seen, wv_ok, wv_k);
    checks++;
    if ({which, wv_ok, tmo, width, det0} !== {1'b0, 1'b1, 1'b0, 22'd60, 1'b0} || wv_k !== 63) begin
      errors++; $display("FAIL miss_60: got sel=%0d tmo=%0d w=%0d det0=%0d k=%0d expected 0 0 60 0 63",
                         which, tmo, width, det0, wv_k);
    end
  endtask

  task automatic test_timeout_measure();
    bit trig_ok, which, wv_gap, other_seen, wv_ok;
    int gap_wait, tlen, wv_k;
    do_ping(200, 0, trig_ok, which, gap_wait, wv_gap, tlen, other_seen, wv_ok, wv_k);
    checks++;
    if ({which, wv_ok, width_id, tmo, width, det1} !== {1'b1, 1'b1, 1'b1, 1'b1, 22'd100, 1'b0}) begin
      errors++; $display("FAIL meas_timeout: got sel=%0d id=%0d tmo=%0d w=%0d det1=%0d expected 1 1 1 100 0",
                         which, width_id, tmo, width, det1);
    end
    checks++;
    if (wv_k !== 102) begin
      errors++; $display("FAIL meas_timeout_time: got k=%0d expected 102", wv_k);
    end
  endtask

  task automatic test_hits();
    int n_tab[7]  = '{40, 20, 40, 20, 49, 20, 50};
    bit s_tab[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit d0_tab[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit d1_tab[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit trig_ok, which, wv_gap, other_seen, wv_ok;
    int gap_wait, tlen, wv_k;
    logic [27:0] act, exp;
    for (int i = 0; i < 7; i++) begin
      do_ping(n_tab[i], 0, trig_ok, which, gap_wait, wv_gap, tlen, other_seen, wv_ok, wv_k);
      act = {which, wv_ok, width_id, tmo, width, det0, det1};
      exp = {s_tab[i], 1'b1, s_tab[i], 1'b0, 22'(n_tab[i]), d0_tab[i], d1_tab[i]};
      checks++;
      if (act !== exp) begin
        errors++; $display("FAIL hits_%0d: got %0h expected %0h", i, act, exp);
      end
      checks++;
      if (gap_wait !== 10 || tlen !== 4) begin
        errors++; $display("FAIL hits_timing_%0d: got gap=%0d len=%0d expected 10 4", i, gap_wait, tlen);
      end
    end
  endtask

  task automatic test_enable_abort();
    bit trig_ok, which, wv_gap, other_seen, wv_ok, wv_seen, trig_any;
    int gap_wait, tlen, wv_k;
    wait_trig(300, trig_ok, which, gap_wait, wv_gap);
    checks++;
    if ({trig_ok, which} !== 2'b11) begin
      errors++; $display("FAIL abort_ping: got ok,sel=%b%b expected 11", trig_ok, which);
    end
    trig_len(which, tlen, other_seen);
    echo1 = 1'b1;
    repeat (15) @(negedge clk);
    enable = 1'b0;
    wv_seen = 1'b0; trig_any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      wv_seen |= width_valid;
      trig_any |= trig0 | trig1;
    end
    checks++;
    if ({wv_seen, trig_any, det0, det1} !== 4'b0000) begin
      errors++; $display("FAIL abort_quiet: got wv,trig,det0,det1=%b%b%b%b expected 0000",
                         wv_seen, trig_any, det0, det1);
    end
    checks++;
    if ({width_id, tmo, width} !== {1'b0, 1'b0, 22'd50}) begin
      errors++; $display("FAIL abort_hold: got id=%0d tmo=%0d w=%0d expected 0 0 50", width_id, tmo, width);
    end
    echo1 = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    do_ping(40, 0, trig_ok, which, gap_wait, wv_gap, tlen, other_seen, wv_ok, wv_k);
    checks++;
    if ({trig_ok, which, wv_ok, width, det0} !== {1'b1, 1'b0, 1'b1, 22'd40, 1'b0} || gap_wait !== 1) begin
      errors++; $display("FAIL reenable_ping: got sel=%0d w=%0d det0=%0d wait=%0d expected 0 40 0 1",
                         which, width, det0, gap_wait);
    end
    do_ping(20, 0, trig_ok, which, gap_wait, wv_gap, tlen, other_seen, wv_ok, wv_k);
    checks++;
    if ({which, wv_ok, width, det1} !== {1'b1, 1'b1, 22'd20, 1'b0}) begin
      errors++; $display("FAIL counter1_cleared: got sel=%0d w=%0d det1=%0d expected 1 20 0", which, width, det1);
    end
  endtask

  task automatic test_reset_mid_ping();
    bit trig_ok, which, wv_gap, other_seen, wv_ok;
    int gap_wait, tlen, wv_k;
    wait_trig(300, trig_ok, which, gap_wait, wv_gap);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({trig0, trig1, width, width_valid, width_id, tmo, det0, det1} !== 29'd0) begin
      errors++;
      $display("FAIL reset_mid_trig: got %0h expected 0",
               {trig0, trig1, width, width_valid, width_id, tmo, det0, det1});
    end
    echo0 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_trig(300, trig_ok, which, gap_wait, wv_gap);
    trig_len(which, tlen, other_seen);
    checks++;
    if ({trig_ok, which} !== 2'b10 || tlen !== 4) begin
      errors++; $display("FAIL post_reset_ping: got ok,sel=%b%b len=%0d expected 10 4", trig_ok, which, tlen);
    end
    wv_k = 0; wv_ok = 1'b0;
    while (!wv_ok && wv_k < 300) begin
      @(negedge clk);
      wv_k++;
      if (wv_k == 20) echo0 = 1'b0;
      if (wv_k == 25) echo0 = 1'b1;
      if (wv_k == 50) echo0 = 1'b0;
      if (width_valid) wv_ok = 1'b1;
    end
    echo0 = 1'b0;
    checks++;
    if (wv_ok !== 1'b1 || wv_k !== 53) begin
      errors++; $display("FAIL high_at_entry_time: got ok=%0d k=%0d expected ok=1 k=53", wv_ok, wv_k);
    end
    checks++;
    if ({width_id, tmo, width} !== {1'b0, 1'b0, 22'd25}) begin
      errors++; $display("FAIL high_at_entry_meas: got id=%0d tmo=%0d w=%0d expected 0 0 25", width_id, tmo, width);
    end
  endtask

  // Main sequence; pings alternate sensors so the scenario order matters.
  initial begin
    test_reset();
    test_basic();
    test_timeout_wait();
    test_long_miss();
    test_timeout_measure();
    test_hits();
    test_enable_abort();
    test_reset_mid_ping();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound in case a scenario loses synchronisation.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000 ns");
    $fatal(1);
  end

endmodule
